// File: rtl/pipe_ctrl.sv
// Purpose: merges per-stage stall requests into the pipeline stall vector, sequences exception flushes, keeps stall counters.
// Latency: stall is combinational with the requests; flush rises one cycle after an accepted excp_req (or after stallreq_mem drops when deferred).
// Backpressure: an outstanding memory stall holds back a flush; later exceptions are dropped while one is pending or flushing.
//
// Ports:
//   clk, rst (async, active-low)
//   stallreq_if/id/ex/mem : per-stage stall requests
//   excp_req, excp_pc     : single-cycle exception pulse and its handler address
//   perf_clr              : synchronous clear of stall_cycles and stall_timeout
//   stall[5:0]            : [0]=pc .. [5]=wb, 1 = hold that register
//   flush, new_pc         : one-cycle squash pulse and redirect target
//   stall_cycles          : saturating count of cycles with stall[0]=1
//   stall_timeout         : sticky watchdog, set after STALL_TIMEOUT consecutive stalled cycles
module pipe_ctrl #(
  parameter int STALL_CNT_W   = 32,
  parameter int STALL_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_if,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic                   excp_req,
  input  logic [31:0]            excp_pc,
  input  logic                   perf_clr,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [31:0]            new_pc,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   stall_timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLUSH_PEND = 2'd1,
    FLUSH      = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_VAL = 16'(STALL_TIMEOUT);

  state_e                 state_q, state_d;
  logic [31:0]            new_pc_q, new_pc_d;
  logic [STALL_CNT_W-1:0] cyc_q, cyc_d;
  logic [15:0]            run_q, run_d;
  logic                   timeout_q, timeout_d;
  logic [5:0]             stall_req;

  // Highest stage wins: a stall in a later stage also holds every earlier one.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_ex) stall_req = 6'b001111;
    else if (stallreq_id) stall_req = 6'b000111;
    else if (stallreq_if) stall_req = 6'b000011;
  end

  // The flush cycle reloads every register, so holding any of them would
  // fight the squash. Reset also masks the vector since it is combinational.
  always_comb begin
    stall = stall_req;
    if (!rst || state_q == FLUSH) stall = 6'b000000;
  end

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      IDLE: begin
        if (excp_req) begin
          new_pc_d = excp_pc;
          state_d  = stallreq_mem ? FLUSH_PEND : FLUSH;
        end
      end
      // The first exception is kept; newer ones come from younger
      // instructions that the flush will squash anyway.
      FLUSH_PEND: begin
        if (!stallreq_mem) state_d = FLUSH;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_d     = cyc_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    if (perf_clr) begin
      cyc_d     = '0;
      run_d     = 16'd0;
      timeout_d = 1'b0;
    end else if (stall[0]) begin
      if (cyc_q != {STALL_CNT_W{1'b1}}) cyc_d = cyc_q + STALL_CNT_W'(1);
      if (run_q != TIMEOUT_VAL) run_d = run_q + 16'd1;
      if (run_d == TIMEOUT_VAL) timeout_d = 1'b1;
    end else begin
      run_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      new_pc_q  <= 32'd0;
      cyc_q     <= '0;
      run_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      cyc_q     <= cyc_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush         = (state_q == FLUSH);
  assign new_pc        = new_pc_q;
  assign stall_cycles  = cyc_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: directed table-driven bench for pipe_ctrl (STALL_CNT_W=3, STALL_TIMEOUT=4).
// Latency: one vector per clock; stall checked before the edge, registered outputs after it.
// Backpressure: none; async reset corner cases are hand-written sequences.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic        perf_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [2:0]  stall_cycles;
  logic        stall_timeout;

  pipe_ctrl #(.STALL_CNT_W(3), .STALL_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_req     (excp_req),
    .excp_pc      (excp_pc),
    .perf_clr     (perf_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cycles (stall_cycles),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;      // {mem, ex, id, if}
    logic        excp;
    logic [31:0] pc;
    logic        clr;
    logic [5:0]  e_stall;  // before the edge
    logic        e_flush;  // after the edge
    logic [31:0] e_pc;
    logic [2:0]  e_cyc;
    logic        e_to;
  } vec_t;

  vec_t vt[64];
  int   nv;
  int   checks;
  int   errors;

  task automatic add(input logic [3:0] req, input logic excp, input logic [31:0] pc,
                     input logic clr, input logic [5:0] es, input logic ef,
                     input logic [31:0] ep, input logic [2:0] ec, input logic et);
    vt[nv].req = req;  vt[nv].excp = excp; vt[nv].pc = pc; vt[nv].clr = clr;
    vt[nv].e_stall = es; vt[nv].e_flush = ef; vt[nv].e_pc = ep;
    vt[nv].e_cyc = ec; vt[nv].e_to = et;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic excp, input logic [31:0] pc,
                       input logic clr);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excp_req = excp;
    excp_pc  = pc;
    perf_clr = clr;
  endtask

  localparam logic [3:0] R0  = 4'b0000;
  localparam logic [3:0] RIF = 4'b0001;
  localparam logic [3:0] RID = 4'b0010;
  localparam logic [3:0] REX = 4'b0100;
  localparam logic [3:0] RME = 4'b1000;

  initial begin
    checks = 0;
    errors = 0;
    nv     = 0;

    // idle and priority
    add(R0,        0, 0, 0, 6'b000000, 0, 32'h0,   0, 0);
    add(RME|RID,   0, 0, 0, 6'b011111, 0, 32'h0,   1, 0);
    add(RID,       0, 0, 0, 6'b000111, 0, 32'h0,   2, 0);
    add(R0,        0, 0, 0, 6'b000000, 0, 32'h0,   2, 0);
    add(RIF,       0, 0, 0, 6'b000011, 0, 32'h0,   3, 0);
    add(REX|RIF,   0, 0, 0, 6'b001111, 0, 32'h0,   4, 0);
    add(R0,        0, 0, 1, 6'b000000, 0, 32'h0,   0, 0);
    // immediate flush; exception and stall during FLUSH are ignored/masked
    add(R0,        1, 32'h100,  0, 6'b000000, 1, 32'h100, 0, 0);
    add(REX,       1, 32'hDEAD, 0, 6'b000000, 0, 32'h100, 0, 0);
    add(R0,        0, 0, 0, 6'b000000, 0, 32'h100, 0, 0);
    // deferred flush: second exception dropped
    add(RME,       1, 32'h200,  0, 6'b011111, 0, 32'h200, 1, 0);
    add(RME,       1, 32'h300,  0, 6'b011111, 0, 32'h200, 2, 0);
    add(RME,       0, 0, 0, 6'b011111, 0, 32'h200, 3, 0);
    add(R0,        0, 0, 0, 6'b000000, 1, 32'h200, 3, 0);
    add(R0,        0, 0, 0, 6'b000000, 0, 32'h200, 3, 0);
    // counters: watchdog at exactly 4 consecutive stalls
    add(R0,        0, 0, 1, 6'b000000, 0, 32'h200, 0, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 1, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 2, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 3, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 4, 1);
    // clear beats increment
    add(REX,       0, 0, 1, 6'b001111, 0, 32'h200, 0, 0);
    // 9 stalled cycles saturate a 3-bit counter at 7
    for (int k = 1; k <= 9; k++)
      add(REX, 0, 0, 0, 6'b001111, 0, 32'h200, (k > 7) ? 3'd7 : 3'(k), (k >= 4));
    add(R0,        0, 0, 0, 6'b000000, 0, 32'h200, 7, 1);
    add(R0,        0, 0, 1, 6'b000000, 0, 32'h200, 0, 0);
    // broken stall runs never reach the watchdog
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 1, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 2, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 3, 0);
    add(R0,        0, 0, 0, 6'b000000, 0, 32'h200, 3, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 4, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 5, 0);
    add(REX,       0, 0, 0, 6'b001111, 0, 32'h200, 6, 0);

    // reset: stall masked even with a request present
    rst = 1'b0;
    drive(RME, 0, 0, 0);
    #12;
    chk("reset_stall",   32'(stall),         32'h0);
    chk("reset_flush",   32'(flush),         32'h0);
    chk("reset_new_pc",  new_pc,             32'h0);
    chk("reset_cycles",  32'(stall_cycles),  32'h0);
    chk("reset_timeout", 32'(stall_timeout), 32'h0);
    @(negedge clk);
    drive(R0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(vt[i].req, vt[i].excp, vt[i].pc, vt[i].clr);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_flush", i),   32'(flush),         32'(vt[i].e_flush));
      chk($sformatf("v%0d_new_pc", i),  new_pc,             vt[i].e_pc);
      chk($sformatf("v%0d_cycles", i),  32'(stall_cycles),  32'(vt[i].e_cyc));
      chk($sformatf("v%0d_timeout", i), 32'(stall_timeout), 32'(vt[i].e_to));
    end

    // async reset while a flush is pending
    @(negedge clk);
    drive(RME, 1, 32'h400, 0);
    @(posedge clk); #1;
    chk("pend_new_pc", new_pc, 32'h400);
    chk("pend_flush",  32'(flush), 32'h0);
    @(negedge clk);
    drive(RME, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_pend_stall",  32'(stall),  32'h0);
    chk("arst_pend_new_pc", new_pc,      32'h0);
    chk("arst_pend_cycles", 32'(stall_cycles), 32'h0);
    @(negedge clk);
    drive(R0, 0, 0, 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_pend_flush%0d", k), 32'(flush), 32'h0);
    end

    // async reset in the middle of the flush cycle
    @(negedge clk);
    drive(R0, 1, 32'h500, 0);
    @(posedge clk); #1;
    chk("pre_arst_flush", 32'(flush), 32'h1);
    drive(R0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_flush_flush",  32'(flush), 32'h0);
    chk("arst_flush_new_pc", new_pc,     32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_flush_flush%0d", k), 32'(flush), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
